// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode/retire/bypass signal bundle for the hazard scoreboard
interface hazard_scoreboard_if #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int STAT_WIDTH           = 32
);
  logic                            issue_valid;
  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_1;
  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_src_2;
  logic                            issue_use_src_1;
  logic                            issue_use_src_2;
  logic                            issue_writes_dst;
  logic [REGISTER_INDEX_WIDTH-1:0] issue_idx_dst;
  logic                            wb_valid;
  logic [REGISTER_INDEX_WIDTH-1:0] wb_idx_dst;
  logic                            fwd_valid;
  logic [REGISTER_INDEX_WIDTH-1:0] fwd_idx_dst;
  logic                            flush;
  logic                            stall;
  logic                            fwd_sel_1;
  logic                            fwd_sel_2;
  logic                            busy;
  logic                            underflow_error;
  logic [STAT_WIDTH-1:0]           stall_cycles;

  modport master (
    output issue_valid, issue_idx_src_1, issue_idx_src_2, issue_use_src_1, issue_use_src_2,
           issue_writes_dst, issue_idx_dst, wb_valid, wb_idx_dst, fwd_valid, fwd_idx_dst, flush,
    input  stall, fwd_sel_1, fwd_sel_2, busy, underflow_error, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_idx_src_1, issue_idx_src_2, issue_use_src_1, issue_use_src_2,
           issue_writes_dst, issue_idx_dst, wb_valid, wb_idx_dst, fwd_valid, fwd_idx_dst, flush,
    output stall, fwd_sel_1, fwd_sel_2, busy, underflow_error, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register in-flight write counters with stall/forward decisions
module hazard_scoreboard #(
  parameter int REGISTER_INDEX_WIDTH = 5,
  parameter int NUM_REGISTERS        = 32,
  parameter int MAX_INFLIGHT         = 3,
  parameter int STAT_WIDTH           = 32
) (
  input  logic              clk,
  input  logic              reset,
  hazard_scoreboard_if.slave sb
);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);
  localparam int RIW = REGISTER_INDEX_WIDTH;

  logic [CW-1:0]         cnt_q [NUM_REGISTERS];
  logic [CW-1:0]         cnt_d [NUM_REGISTERS];
  logic                  underflow_q, underflow_d;
  logic [STAT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // r0 and indices beyond the register file are never tracked
  function automatic logic tracked(input logic [RIW-1:0] idx);
    return (idx != '0) && (32'(idx) < NUM_REGISTERS);
  endfunction

  function automatic logic [CW-1:0] cnt_of(input logic [RIW-1:0] idx);
    logic [CW-1:0] c;
    c = '0;
    if (tracked(idx)) c = cnt_q[idx];
    return c;
  endfunction

  logic [CW-1:0] cnt_src_1, cnt_src_2, cnt_dst, cnt_wb;
  logic          haz_1, haz_2, fwd_ok_1, fwd_ok_2, full, stall_w, accept, busy_w;

  always_comb begin
    cnt_src_1 = cnt_of(sb.issue_idx_src_1);
    cnt_src_2 = cnt_of(sb.issue_idx_src_2);
    cnt_dst   = cnt_of(sb.issue_idx_dst);
    cnt_wb    = cnt_of(sb.wb_idx_dst);

    haz_1 = sb.issue_valid & sb.issue_use_src_1 & (cnt_src_1 != '0);
    haz_2 = sb.issue_valid & sb.issue_use_src_2 & (cnt_src_2 != '0);

    // Bypass only covers the hazard when it carries the sole outstanding write
    fwd_ok_1 = sb.fwd_valid & (sb.fwd_idx_dst == sb.issue_idx_src_1) & (cnt_src_1 == CW'(1));
    fwd_ok_2 = sb.fwd_valid & (sb.fwd_idx_dst == sb.issue_idx_src_2) & (cnt_src_2 == CW'(1));

    full = sb.issue_valid & sb.issue_writes_dst & tracked(sb.issue_idx_dst) &
           (cnt_dst == CW'(MAX_INFLIGHT));

    stall_w = ((haz_1 & ~fwd_ok_1) | (haz_2 & ~fwd_ok_2) | full) & ~sb.flush;
    accept  = sb.issue_valid & ~stall_w & ~sb.flush;

    busy_w = 1'b0;
    for (int r = 1; r < NUM_REGISTERS; r++) begin
      busy_w = busy_w | (cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGISTERS; r++) begin
      cnt_d[r] = '0;
      if (r != 0 && !sb.flush) begin
        cnt_d[r] = cnt_q[r]
                 + CW'(accept & sb.issue_writes_dst & (sb.issue_idx_dst == RIW'(r)))
                 - CW'(sb.wb_valid & (sb.wb_idx_dst == RIW'(r)) & (cnt_q[r] != '0));
      end
    end

    underflow_d = underflow_q | (sb.wb_valid & tracked(sb.wb_idx_dst) & (cnt_wb == '0));

    stall_cnt_d = stall_cnt_q;
    if (stall_w && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STAT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGISTERS; r++) cnt_q[r] <= '0;
      underflow_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGISTERS; r++) cnt_q[r] <= cnt_d[r];
      underflow_q <= underflow_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign sb.stall           = stall_w;
  assign sb.fwd_sel_1       = haz_1 & fwd_ok_1 & ~sb.flush;
  assign sb.fwd_sel_2       = haz_2 & fwd_ok_2 & ~sb.flush;
  assign sb.busy            = busy_w;
  assign sb.underflow_error = underflow_q;
  assign sb.stall_cycles    = stall_cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard (STAT_WIDTH=4 build)
module tb_hazard_scoreboard;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  hazard_scoreboard_if #(.REGISTER_INDEX_WIDTH(5), .STAT_WIDTH(4)) sb ();

  hazard_scoreboard #(
    .REGISTER_INDEX_WIDTH(5),
    .NUM_REGISTERS(32),
    .MAX_INFLIGHT(3),
    .STAT_WIDTH(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sb   (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [4:0] s1;
    logic       u1;
    logic [4:0] s2;
    logic       u2;
    logic       wd;
    logic [4:0] d;
    logic       wv;
    logic [4:0] wi;
    logic       fv;
    logic [4:0] fi;
    logic       fl;
    logic       e_st;
    logic       e_f1;
    logic       e_f2;
    logic       e_busy;
    logic       e_uerr;
    int         e_sc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic iv, int s1, logic u1, int s2, logic u2, logic wd, int d,
                              logic wv, int wi, logic fv, int fi, logic fl,
                              logic st, logic f1, logic f2, logic bz, logic ue, int sc);
    vec_t v;
    v.iv = iv; v.s1 = 5'(s1); v.u1 = u1; v.s2 = 5'(s2); v.u2 = u2;
    v.wd = wd; v.d = 5'(d); v.wv = wv; v.wi = 5'(wi); v.fv = fv; v.fi = 5'(fi); v.fl = fl;
    v.e_st = st; v.e_f1 = f1; v.e_f2 = f2; v.e_busy = bz; v.e_uerr = ue; v.e_sc = sc;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    sb.issue_valid      = v.iv;
    sb.issue_idx_src_1  = v.s1;
    sb.issue_use_src_1  = v.u1;
    sb.issue_idx_src_2  = v.s2;
    sb.issue_use_src_2  = v.u2;
    sb.issue_writes_dst = v.wd;
    sb.issue_idx_dst    = v.d;
    sb.wb_valid         = v.wv;
    sb.wb_idx_dst       = v.wi;
    sb.fwd_valid        = v.fv;
    sb.fwd_idx_dst      = v.fi;
    sb.flush            = v.fl;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".stall"}, int'(sb.stall), int'(v.e_st));
    check({tag, ".fwd_sel_1"}, int'(sb.fwd_sel_1), int'(v.e_f1));
    check({tag, ".fwd_sel_2"}, int'(sb.fwd_sel_2), int'(v.e_f2));
    check({tag, ".busy"}, int'(sb.busy), int'(v.e_busy));
    check({tag, ".underflow"}, int'(sb.underflow_error), int'(v.e_uerr));
    check({tag, ".stall_cycles"}, int'(sb.stall_cycles), v.e_sc);
  endtask

  vec_t idle, v;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle  = mk(0,0,0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0);
    //          iv s1 u1 s2 u2 wd d  wv wi fv fi fl  st f1 f2 bz ue sc
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0,0));
    tbl.push_back(mk(1, 0,0, 0,0, 1,3, 0,0, 0,0, 0,  0,0,0,0,0,0));
    tbl.push_back(mk(1, 3,1, 0,0, 0,0, 0,0, 0,0, 0,  1,0,0,1,0,0));
    tbl.push_back(mk(1, 3,1, 0,0, 0,0, 1,3, 0,0, 0,  1,0,0,1,0,1));
    tbl.push_back(mk(1, 3,1, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0,2));
    tbl.push_back(mk(1, 0,0, 0,0, 1,5, 0,0, 0,0, 0,  0,0,0,0,0,2));
    tbl.push_back(mk(1, 0,0, 5,1, 0,0, 0,0, 1,5, 0,  0,0,1,1,0,2));
    tbl.push_back(mk(1, 0,0, 0,0, 1,5, 0,0, 0,0, 0,  0,0,0,1,0,2));
    tbl.push_back(mk(1, 0,0, 5,1, 0,0, 0,0, 1,5, 0,  1,0,0,1,0,2));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,5, 0,0, 0,  0,0,0,1,0,3));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,5, 0,0, 0,  0,0,0,1,0,3));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  0,0,0,0,0,3));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  0,0,0,1,0,3));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  0,0,0,1,0,3));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  1,0,0,1,0,3));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 1,7, 0,0, 0,  1,0,0,1,0,4));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  0,0,0,1,0,5));
    tbl.push_back(mk(1, 0,0, 0,0, 1,7, 0,0, 0,0, 0,  1,0,0,1,0,5));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 0,0, 0,  0,0,0,1,0,6));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 0,0, 0,  0,0,0,1,0,6));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 0,0, 0,  0,0,0,1,0,6));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,0,6));
    tbl.push_back(mk(1, 0,1, 0,1, 1,0, 0,0, 0,0, 0,  0,0,0,0,0,6));
    tbl.push_back(mk(1, 0,1, 0,1, 1,0, 0,0, 0,0, 0,  0,0,0,0,0,6));
    tbl.push_back(mk(1, 0,0, 0,0, 1,4, 0,0, 0,0, 0,  0,0,0,0,0,6));
    tbl.push_back(mk(1, 4,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,1,0,6));
    tbl.push_back(mk(1, 4,1, 0,0, 0,0, 0,0, 0,0, 0,  1,0,0,1,0,6));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,4, 0,0, 0,  0,0,0,1,0,7));
    tbl.push_back(mk(1, 0,0, 0,0, 1,2, 0,0, 0,0, 0,  0,0,0,0,0,7));
    tbl.push_back(mk(1, 0,0, 0,0, 1,9, 0,0, 0,0, 0,  0,0,0,1,0,7));
    tbl.push_back(mk(1, 2,1, 9,1, 1,2, 0,0, 1,9, 1,  0,0,0,1,0,7));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 1,2, 0,0, 0,  0,0,0,0,0,7));
    tbl.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,0, 0,  0,0,0,0,1,7));
    tbl.push_back(mk(1, 0,0, 0,0, 1,9, 0,0, 0,0, 0,  0,0,0,0,1,7));

    drive(idle);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outs("in_reset", idle);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #4;
      check_outs($sformatf("vec%0d", i), tbl[i]);
    end

    // Async reset lands between edges while a stall is active
    @(negedge clk);
    drive(mk(1,0,0,0,0,1,3, 0,0,0,0,0, 0,0,0,0,0,0));
    @(negedge clk);
    drive(mk(1,3,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("pre_reset.stall", int'(sb.stall), 1);
    check("pre_reset.stall_cycles", int'(sb.stall_cycles), 9);
    #1 reset = 1'b1;
    #1;
    check("async_reset.stall", int'(sb.stall), 0);
    check("async_reset.busy", int'(sb.busy), 0);
    check("async_reset.stall_cycles", int'(sb.stall_cycles), 0);
    check("async_reset.underflow", int'(sb.underflow_error), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(1,0,0,0,0,1,3, 0,0,0,0,0, 0,0,0,0,0,0));

    // Saturation of the 4-bit stall counter
    @(negedge clk);
    drive(mk(1,3,1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0));
    repeat (14) @(posedge clk);
    @(negedge clk);
    check("sat.stall_cycles_14", int'(sb.stall_cycles), 14);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("sat.stall_cycles_15", int'(sb.stall_cycles), 15);
    check("sat.stall", int'(sb.stall), 1);
    @(posedge clk);
    @(negedge clk);
    check("sat.hold", int'(sb.stall_cycles), 15);

    drive(idle);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
